port_rd_scheduler: RTL and testbench



---
 rtl/hydra_pkg.sv | 19 +
 rtl/prior_picker.sv | 24 ++
 rtl/port_rd_scheduler.sv | 115 +++++++++++
 tb/tb_port_rd_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hydra_pkg.sv
// Definitions shared by the port-side scheduling blocks: sizes, WRR weights
// and the read-scheduler state encoding.
package hydra_pkg;

   localparam int NUM_PORT  = 16;
   localparam int NUM_PRIOR = 8;
   localparam int NUM_SRAM  = 32;

   // Packets per WRR round for each priority; priority 0 gets the largest share.
   localparam logic [3:0] WRR_WEIGHT [NUM_PRIOR] =
      '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2
   } sched_state_t;

endpackage

// File: rtl/prior_picker.sv
// Combinational lowest-index-set-bit finder: idx is the lowest set bit of
// mask, found says whether any bit is set (idx is 0 when none is).
module prior_picker #(
   parameter int N  = 8,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  mask,
   output logic [IW-1:0] idx,
   output logic          found
);

   always_comb begin
      idx   = '0;
      found = 1'b0;
      // Scan from the top so the lowest set bit is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (mask[i]) begin
            idx   = IW'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/port_rd_scheduler.sv
// Per-port packet scheduler: picks the next priority queue (strict or WRR)
// and runs the request/ack handshake with the port read engine.
module port_rd_scheduler #(
   parameter int NUM_PRIOR = 8,
   parameter int CREDIT_W  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wrr_en,
   input  logic [NUM_PRIOR-1:0]          queue_vld,
   input  logic                          ready,
   output logic                          deq_vld,
   output logic [2:0]                    deq_prior,
   input  logic                          deq_ack,
   input  logic                          pkt_done,
   output logic                          busy,
   output logic [1:0]                    dbg_state,
   output logic [NUM_PRIOR*CREDIT_W-1:0] dbg_credit
);

   import hydra_pkg::*;

   // Handshake: deq_vld/deq_prior rise together and stay frozen until the
   // cycle deq_ack is seen high; the request is never withdrawn early.
   // pkt_done is only honoured once the request has been acknowledged.

   sched_state_t         state;
   logic                 wrr_active;
   logic [CREDIT_W-1:0]  credit [NUM_PRIOR];
   logic [NUM_PRIOR-1:0] eligible;
   logic [2:0]           elig_idx;
   logic [2:0]           vld_idx;
   logic                 elig_found;
   logic                 vld_found;

   always_comb begin
      eligible = '0;
      for (int p = 0; p < NUM_PRIOR; p++) begin
         eligible[p] = queue_vld[p] && (credit[p] != '0);
      end
   end

   prior_picker #(.N(NUM_PRIOR)) u_pick_elig (
      .mask  (eligible),
      .idx   (elig_idx),
      .found (elig_found)
   );

   prior_picker #(.N(NUM_PRIOR)) u_pick_vld (
      .mask  (queue_vld),
      .idx   (vld_idx),
      .found (vld_found)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         deq_vld    <= 1'b0;
         deq_prior  <= '0;
         busy       <= 1'b0;
         wrr_active <= 1'b0;
         for (int p = 0; p < NUM_PRIOR; p++) begin
            credit[p] <= CREDIT_W'(WRR_WEIGHT[p]);
         end
      end else begin
         case (state)
            IDLE: begin
               if (ready && vld_found) begin
                  deq_vld    <= 1'b1;
                  busy       <= 1'b1;
                  wrr_active <= wrr_en;
                  state      <= REQ;
                  if (wrr_en && elig_found) begin
                     deq_prior <= elig_idx;
                  end else begin
                     deq_prior <= vld_idx;
                     // WRR round exhausted for every waiting queue: start a new round.
                     if (wrr_en) begin
                        for (int p = 0; p < NUM_PRIOR; p++) begin
                           credit[p] <= CREDIT_W'(WRR_WEIGHT[p]);
                        end
                     end
                  end
               end
            end
            REQ: begin
               if (deq_ack) begin
                  deq_vld <= 1'b0;
                  state   <= XFER;
                  if (wrr_active) begin
                     credit[deq_prior] <= credit[deq_prior] - CREDIT_W'(1);
                  end
               end
            end
            XFER: begin
               if (pkt_done) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign dbg_state = state;

   always_comb begin
      dbg_credit = '0;
      for (int p = 0; p < NUM_PRIOR; p++) begin
         dbg_credit[p*CREDIT_W +: CREDIT_W] = credit[p];
      end
   end

endmodule

// File: tb/tb_port_rd_scheduler.sv
// Bench for port_rd_scheduler: table of single-packet vectors plus
// hand-written multi-cycle sequences, grants checked through a queue.
module tb_port_rd_scheduler;

   import hydra_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        wrr_en;
   logic [7:0]  queue_vld;
   logic        ready;
   logic        deq_vld;
   logic [2:0]  deq_prior;
   logic        deq_ack;
   logic        pkt_done;
   logic        busy;
   logic [1:0]  dbg_state;
   logic [31:0] dbg_credit;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [2:0] exp_q[$];

   typedef struct {
      logic       wrr;
      logic [7:0] qv;
      logic [2:0] exp_prior;
      int         hold;
      logic [2:0] chk_q;
      logic [3:0] chk_val;
   } vec_t;

   vec_t vecs[10];

   port_rd_scheduler #(.NUM_PRIOR(8), .CREDIT_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .wrr_en     (wrr_en),
      .queue_vld  (queue_vld),
      .ready      (ready),
      .deq_vld    (deq_vld),
      .deq_prior  (deq_prior),
      .deq_ack    (deq_ack),
      .pkt_done   (pkt_done),
      .busy       (busy),
      .dbg_state  (dbg_state),
      .dbg_credit (dbg_credit)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] credit_of(input int q);
      return dbg_credit[q*4 +: 4];
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; wrr_en = 1'b0; queue_vld = '0; ready = 1'b0;
      deq_ack = 1'b0; pkt_done = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // One complete packet: select, hold the ack off for `hold` cycles, ack, done.
   task automatic run_pkt(input logic wrr, input logic [7:0] qv, input logic [2:0] exp,
                          input int hold, input logic drop_qv, output logic [2:0] got);
      logic [2:0] e;
      int         waited;
      wrr_en = wrr; queue_vld = qv; ready = 1'b1;
      exp_q.push_back(exp);
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!deq_vld && waited < 10);
      ready = 1'b0;
      if (drop_qv) queue_vld = '0;
      e = exp_q.pop_front();
      check("req_seen", {31'd0, deq_vld}, 32'd1);
      check("deq_prior", {29'd0, deq_prior}, {29'd0, e});
      check("busy_req", {31'd0, busy}, 32'd1);
      got = deq_prior;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_vld", {31'd0, deq_vld}, 32'd1);
         check("hold_prior", {29'd0, deq_prior}, {29'd0, e});
      end
      deq_ack = 1'b1;
      @(negedge clk);
      deq_ack = 1'b0;
      check("xfer_state", {30'd0, dbg_state}, {30'd0, XFER});
      check("vld_drop", {31'd0, deq_vld}, 32'd0);
      pkt_done = 1'b1;
      @(negedge clk);
      pkt_done = 1'b0;
      check("idle_state", {30'd0, dbg_state}, {30'd0, IDLE});
      check("busy_done", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [2:0] got;
      int         cnt0;
      int         cnt7;

      vecs[0] = '{1'b0, 8'h84, 3'd2, 5, 3'd2, 4'd6};
      vecs[1] = '{1'b0, 8'h80, 3'd7, 0, 3'd7, 4'd1};
      vecs[2] = '{1'b1, 8'h06, 3'd1, 1, 3'd1, 4'd6};
      vecs[3] = '{1'b1, 8'h80, 3'd7, 0, 3'd7, 4'd0};
      vecs[4] = '{1'b1, 8'h80, 3'd7, 2, 3'd1, 4'd7};
      vecs[5] = '{1'b1, 8'hC0, 3'd6, 0, 3'd6, 4'd1};
      vecs[6] = '{1'b1, 8'hC0, 3'd6, 0, 3'd6, 4'd0};
      vecs[7] = '{1'b1, 8'hC0, 3'd6, 3, 3'd7, 4'd1};
      vecs[8] = '{1'b0, 8'hFF, 3'd0, 0, 3'd0, 4'd8};
      vecs[9] = '{1'b1, 8'h05, 3'd0, 1, 3'd0, 4'd7};

      // Reset then idle with ready high and nothing queued.
      do_reset();
      ready = 1'b1;
      @(negedge clk);
      check("rst_deq_vld", {31'd0, deq_vld}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_prior", {29'd0, deq_prior}, 32'd0);
      check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
      check("rst_credits", dbg_credit, 32'h1234_5678);
      ready = 1'b0;

      // Table-driven single packets, continuing credit state from reset.
      for (int v = 0; v < 10; v++) begin
         run_pkt(vecs[v].wrr, vecs[v].qv, vecs[v].exp_prior, vecs[v].hold,
                 vecs[v].hold > 0, got);
         check($sformatf("vec%0d_credit", v), {28'd0, credit_of(int'(vecs[v].chk_q))},
               {28'd0, vecs[v].chk_val});
      end

      // WRR ratio with queues 0 and 7 always valid.
      do_reset();
      cnt0 = 0;
      cnt7 = 0;
      for (int k = 0; k < 90; k++) begin
         run_pkt(1'b1, 8'h81, (k % 9 == 8) ? 3'd7 : 3'd0, 0, 1'b0, got);
         if (got == 3'd0) cnt0++;
         if (got == 3'd7) cnt7++;
      end
      check("ratio_q0", cnt0, 32'd80);
      check("ratio_q7", cnt7, 32'd10);

      // Ignored and simultaneous events.
      do_reset();
      queue_vld = 8'h01; wrr_en = 1'b1; pkt_done = 1'b1; deq_ack = 1'b1;
      @(negedge clk);
      pkt_done = 1'b0; deq_ack = 1'b0;
      check("ign_idle_state", {30'd0, dbg_state}, {30'd0, IDLE});
      check("ign_idle_busy", {31'd0, busy}, 32'd0);
      check("ign_idle_credit", {28'd0, credit_of(0)}, 32'd8);
      ready = 1'b1;
      exp_q.push_back(3'd0);
      @(negedge clk);
      ready = 1'b0;
      check("ign_prior", {29'd0, deq_prior}, {29'd0, exp_q.pop_front()});
      check("ign_req_state", {30'd0, dbg_state}, {30'd0, REQ});
      pkt_done = 1'b1;
      @(negedge clk);
      pkt_done = 1'b0;
      check("ign_req_hold", {30'd0, dbg_state}, {30'd0, REQ});
      check("ign_req_vld", {31'd0, deq_vld}, 32'd1);
      deq_ack = 1'b1; pkt_done = 1'b1;
      @(negedge clk);
      deq_ack = 1'b0; pkt_done = 1'b0;
      check("both_state", {30'd0, dbg_state}, {30'd0, XFER});
      check("both_busy", {31'd0, busy}, 32'd1);
      check("both_credit", {28'd0, credit_of(0)}, 32'd7);
      @(negedge clk);
      check("both_still_xfer", {30'd0, dbg_state}, {30'd0, XFER});
      pkt_done = 1'b1;
      @(negedge clk);
      pkt_done = 1'b0;
      check("both_done_state", {30'd0, dbg_state}, {30'd0, IDLE});
      check("both_done_busy", {31'd0, busy}, 32'd0);

      // Reset in the middle of a transfer.
      do_reset();
      for (int k = 0; k < 4; k++) run_pkt(1'b1, 8'h01, 3'd0, 0, 1'b0, got);
      check("mid_credit_pre", {28'd0, credit_of(0)}, 32'd4);
      wrr_en = 1'b1; queue_vld = 8'h01; ready = 1'b1;
      exp_q.push_back(3'd0);
      @(negedge clk);
      ready = 1'b0;
      check("mid_prior", {29'd0, deq_prior}, {29'd0, exp_q.pop_front()});
      deq_ack = 1'b1;
      @(negedge clk);
      deq_ack = 1'b0;
      check("mid_xfer", {30'd0, dbg_state}, {30'd0, XFER});
      check("mid_credit3", {28'd0, credit_of(0)}, 32'd3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
      check("mid_rst_vld", {31'd0, deq_vld}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_credit", {28'd0, credit_of(0)}, 32'd8);

      // Mode switch keeps credit state.
      do_reset();
      for (int k = 0; k < 3; k++) run_pkt(1'b1, 8'h01, 3'd0, 0, 1'b0, got);
      check("sw_credit_wrr", {28'd0, credit_of(0)}, 32'd5);
      run_pkt(1'b0, 8'h03, 3'd0, 0, 1'b0, got);
      check("sw_credit_sp", {28'd0, credit_of(0)}, 32'd5);
      run_pkt(1'b1, 8'h03, 3'd0, 0, 1'b0, got);
      check("sw_credit_back", {28'd0, credit_of(0)}, 32'd4);

      check("exp_q_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
